// File: rtl/simple_pkg.sv
// ---------------------------------------------------------------------------
// simple_pkg
// Shared constants for the SIMPLE pipeline writeback stage.
//   DATA_W        : register and datapath width
//   REG_N         : number of architectural registers
//   ADDR_W        : register address width
//   PEND_W        : width of each pending-write counter
//   PEND_MAX      : largest value a pending counter can hold
//   REG_RESET_VAL : value every register takes on reset
// ---------------------------------------------------------------------------
package simple_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int ADDR_W = 3;
    localparam int PEND_W = 2;

    localparam logic [PEND_W-1:0] PEND_MAX      = '1;
    localparam logic [DATA_W-1:0] REG_RESET_VAL = 16'h0000;

endpackage

// File: rtl/p5_writeback_if.sv
// ---------------------------------------------------------------------------
// p5_writeback_if
// Bundle of every non-clock signal between the writeback stage and its
// neighbours (memory-access result, decode read ports, decode issue port).
//   wbData/wbWrite/wbAddr       : committed result from memory access
//   readAddrA/B, readUseA/B     : decode source operands
//   issueValid/Write/Addr       : decode issue request
//   readDataA/B                 : bypassed register values
//   stall                       : decode must hold
//   scoreboardError             : sticky pending-counter fault
//   writebackCount              : commits since reset
// Modports: master = pipeline side driving requests, slave = writeback stage.
// ---------------------------------------------------------------------------
interface p5_writeback_if;
    import simple_pkg::*;

    logic [DATA_W-1:0] wbData;
    logic              wbWrite;
    logic [ADDR_W-1:0] wbAddr;
    logic [ADDR_W-1:0] readAddrA;
    logic [ADDR_W-1:0] readAddrB;
    logic              readUseA;
    logic              readUseB;
    logic              issueValid;
    logic              issueWrite;
    logic [ADDR_W-1:0] issueAddr;
    logic [DATA_W-1:0] readDataA;
    logic [DATA_W-1:0] readDataB;
    logic              stall;
    logic              scoreboardError;
    logic [15:0]       writebackCount;

    modport master (
        output wbData, wbWrite, wbAddr,
        output readAddrA, readAddrB, readUseA, readUseB,
        output issueValid, issueWrite, issueAddr,
        input  readDataA, readDataB, stall, scoreboardError, writebackCount
    );

    modport slave (
        input  wbData, wbWrite, wbAddr,
        input  readAddrA, readAddrB, readUseA, readUseB,
        input  issueValid, issueWrite, issueAddr,
        output readDataA, readDataB, stall, scoreboardError, writebackCount
    );

endinterface

// File: rtl/p5_writeback_regfile.sv
// ---------------------------------------------------------------------------
// regfile8x16
// Architectural register file with two write-through read ports.
//   clock, resetN          : clock and asynchronous active-low reset
//   i_wbData/i_wbWrite/i_wbAddr : commit port
//   i_readAddrA/B          : read addresses
//   o_readDataA/B          : register value, or the committing value when the
//                            same register is written this cycle
// ---------------------------------------------------------------------------
module regfile8x16
    import simple_pkg::*;
(
    input  logic              clock,
    input  logic              resetN,
    input  logic [DATA_W-1:0] i_wbData,
    input  logic              i_wbWrite,
    input  logic [ADDR_W-1:0] i_wbAddr,
    input  logic [ADDR_W-1:0] i_readAddrA,
    input  logic [ADDR_W-1:0] i_readAddrB,
    output logic [DATA_W-1:0] o_readDataA,
    output logic [DATA_W-1:0] o_readDataB
);

    logic [DATA_W-1:0] r_regs [REG_N];

    // Register array: every register, including r0, is general purpose.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= REG_RESET_VAL;
            end
        end else if (i_wbWrite) begin
            r_regs[i_wbAddr] <= i_wbData;
        end
    end

    // Bypass lets decode see a result in the same cycle it commits.
    always_comb begin
        o_readDataA = r_regs[i_readAddrA];
        o_readDataB = r_regs[i_readAddrB];
        if (i_wbWrite && (i_wbAddr == i_readAddrA)) begin
            o_readDataA = i_wbData;
        end
        if (i_wbWrite && (i_wbAddr == i_readAddrB)) begin
            o_readDataB = i_wbData;
        end
    end

endmodule

// File: rtl/p5_writeback.sv
// ---------------------------------------------------------------------------
// p5_writeback
// Writeback stage: commits results into the register file, serves bypassed
// reads to decode, and keeps a per-register pending-write scoreboard that
// stalls decode on read-after-write hazards and counter saturation.
//   clock, resetN : clock and asynchronous active-low reset
//   bus           : p5_writeback_if slave (commit, read, issue, status)
// ---------------------------------------------------------------------------
module p5_writeback
    import simple_pkg::*;
(
    input  logic           clock,
    input  logic           resetN,
    p5_writeback_if.slave  bus
);

    logic [PEND_W-1:0] r_pending [REG_N];
    logic              r_scoreboardError;
    logic [15:0]       r_writebackCount;

    logic [REG_N-1:0]  w_dec;
    logic [REG_N-1:0]  w_inc;
    logic [PEND_W-1:0] w_effA;
    logic [PEND_W-1:0] w_effB;
    logic              w_stall;
    logic [DATA_W-1:0] w_readDataA;
    logic [DATA_W-1:0] w_readDataB;

    regfile8x16 u_regfile (
        .clock       (clock),
        .resetN      (resetN),
        .i_wbData    (bus.wbData),
        .i_wbWrite   (bus.wbWrite),
        .i_wbAddr    (bus.wbAddr),
        .i_readAddrA (bus.readAddrA),
        .i_readAddrB (bus.readAddrB),
        .o_readDataA (w_readDataA),
        .o_readDataB (w_readDataB)
    );

    // One decrement strobe per register for the commit happening this cycle.
    always_comb begin
        w_dec = '0;
        for (int r = 0; r < REG_N; r++) begin
            w_dec[r] = bus.wbWrite && (bus.wbAddr == ADDR_W'(r));
        end
    end

    // A commit landing this cycle already resolves one pending write, so it
    // is subtracted before deciding whether a source is still outstanding.
    // The saturation term keeps an issue from pushing a counter past 3.
    always_comb begin
        w_effA  = r_pending[bus.readAddrA] - PEND_W'(w_dec[bus.readAddrA]);
        w_effB  = r_pending[bus.readAddrB] - PEND_W'(w_dec[bus.readAddrB]);
        w_stall = bus.issueValid &&
                  ((bus.readUseA && (w_effA != '0)) ||
                   (bus.readUseB && (w_effB != '0)) ||
                   (bus.issueWrite && (r_pending[bus.issueAddr] == PEND_MAX) &&
                    !w_dec[bus.issueAddr]));
    end

    // Increment strobes only for issues that are actually accepted.
    always_comb begin
        w_inc = '0;
        for (int r = 0; r < REG_N; r++) begin
            w_inc[r] = bus.issueValid && bus.issueWrite &&
                       (bus.issueAddr == ADDR_W'(r)) && !w_stall;
        end
    end

    // Scoreboard counters: inc and dec on the same edge cancel out. An
    // unmatched commit or an impossible overflow holds the counter and
    // raises the sticky error flag.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < REG_N; r++) begin
                r_pending[r] <= '0;
            end
            r_scoreboardError <= 1'b0;
        end else begin
            for (int r = 0; r < REG_N; r++) begin
                case ({w_inc[r], w_dec[r]})
                    2'b10: begin
                        if (r_pending[r] == PEND_MAX) begin
                            r_scoreboardError <= 1'b1;
                        end else begin
                            r_pending[r] <= r_pending[r] + PEND_W'(1);
                        end
                    end
                    2'b01: begin
                        if (r_pending[r] == '0) begin
                            r_scoreboardError <= 1'b1;
                        end else begin
                            r_pending[r] <= r_pending[r] - PEND_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Commit counter, free-running modulo 2^16.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_writebackCount <= 16'h0000;
        end else if (bus.wbWrite) begin
            r_writebackCount <= r_writebackCount + 16'h0001;
        end
    end

    assign bus.readDataA       = w_readDataA;
    assign bus.readDataB       = w_readDataB;
    assign bus.stall           = w_stall;
    assign bus.scoreboardError = r_scoreboardError;
    assign bus.writebackCount  = r_writebackCount;

endmodule

// File: tb/tb_p5_writeback.sv
// ---------------------------------------------------------------------------
// tb_p5_writeback
// Directed bench for p5_writeback with a reference model held as plain
// integer arrays (register values, outstanding-write counts, error flag,
// commit count). Outputs are compared against the model every falling edge;
// directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_p5_writeback;
    import simple_pkg::*;

    logic clock  = 1'b0;
    logic resetN = 1'b1;

    p5_writeback_if bus ();

    p5_writeback u_dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int checks      = 0;
    int errors      = 0;
    bit checkEnable = 1'b0;

    logic [15:0] mRegs [8];
    int          mPend [8];
    bit          mErr;
    int          mCount;

    // Free-running clock, period 10.
    initial begin
        forever #5 clock = ~clock;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outstanding writes to a register, minus the one retiring right now.
    function automatic int expEff(input int a);
        return mPend[a] - ((bus.wbWrite && int'(bus.wbAddr) == a) ? 1 : 0);
    endfunction

    function automatic bit expStall();
        bit hazard;
        bit full;
        hazard = (bus.readUseA && expEff(int'(bus.readAddrA)) != 0) ||
                 (bus.readUseB && expEff(int'(bus.readAddrB)) != 0);
        full   = bus.issueWrite && mPend[int'(bus.issueAddr)] == 3 &&
                 !(bus.wbWrite && bus.wbAddr == bus.issueAddr);
        return bus.issueValid && (hazard || full);
    endfunction

    function automatic logic [15:0] expRead(input logic [2:0] a);
        if (bus.wbWrite && bus.wbAddr == a) return bus.wbData;
        return mRegs[a];
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < 8; r++) begin
                mRegs[r] = 16'h0000;
                mPend[r] = 0;
            end
            mErr   = 1'b0;
            mCount = 0;
        end else begin
            bit accepted;
            accepted = bus.issueValid && !expStall();
            for (int r = 0; r < 8; r++) begin
                int delta;
                delta = 0;
                if (accepted && bus.issueWrite && int'(bus.issueAddr) == r) delta = delta + 1;
                if (bus.wbWrite && int'(bus.wbAddr) == r) delta = delta - 1;
                if (mPend[r] + delta < 0) mErr = 1'b1;
                else if (mPend[r] + delta > 3) mErr = 1'b1;
                else mPend[r] = mPend[r] + delta;
            end
            if (bus.wbWrite) begin
                mRegs[bus.wbAddr] = bus.wbData;
                mCount = (mCount + 1) % 65536;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (checkEnable) begin
            checkOutput("modelReadDataA", bus.readDataA, expRead(bus.readAddrA));
            checkOutput("modelReadDataB", bus.readDataB, expRead(bus.readAddrB));
            checkOutput("modelStall", bus.stall, expStall());
            checkOutput("modelError", bus.scoreboardError, mErr);
            checkOutput("modelCount", bus.writebackCount, mCount[15:0]);
        end
    end

    task automatic applyStimulus(input bit iv, input bit iw, input logic [2:0] ia,
                                 input logic [2:0] ra, input bit ua,
                                 input logic [2:0] rb, input bit ub,
                                 input bit ww, input logic [2:0] wa,
                                 input logic [15:0] wd);
        bus.issueValid = iv;
        bus.issueWrite = iw;
        bus.issueAddr  = ia;
        bus.readAddrA  = ra;
        bus.readUseA   = ua;
        bus.readAddrB  = rb;
        bus.readUseB   = ub;
        bus.wbWrite    = ww;
        bus.wbAddr     = wa;
        bus.wbData     = wd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        #1;
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        checkEnable = 1'b1;
        @(negedge clock);
        checkOutput("resetCount", bus.writebackCount, 16'h0000);
        checkOutput("resetError", bus.scoreboardError, 1'b0);
        tick();

        // Some traffic, then a mid-run reset that must discard it.
        applyStimulus(1, 1, 4, 2, 0, 4, 0, 1, 2, 16'h5555);
        tick();
        applyStimulus(0, 0, 0, 2, 0, 4, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("preResetRegR2", bus.readDataA, 16'h5555);
        checkOutput("preResetError", bus.scoreboardError, 1'b1);
        tick();
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("midResetRegR2", bus.readDataA, 16'h0000);
        checkOutput("midResetError", bus.scoreboardError, 1'b0);
        tick();
        resetN = 1'b1;

        // Reset then write through r5.
        applyStimulus(0, 0, 0, 5, 0, 5, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("r5AfterReset", bus.readDataA, 16'h0000);
        tick();
        applyStimulus(0, 0, 0, 5, 0, 5, 0, 1, 5, 16'h1234);
        @(negedge clock);
        checkOutput("r5Bypass", bus.readDataA, 16'h1234);
        tick();
        bus.wbWrite = 1'b0;
        @(negedge clock);
        checkOutput("r5Array", bus.readDataB, 16'h1234);
        checkOutput("countAfterOne", bus.writebackCount, 16'h0001);
        tick();
        doReset();

        // RAW hazard on r3.
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("issueR3Accepted", bus.stall, 1'b0);
        tick();
        applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("rawStall", bus.stall, 1'b1);
        tick();
        applyStimulus(1, 0, 0, 3, 1, 0, 0, 1, 3, 16'hABCD);
        @(negedge clock);
        checkOutput("rawResolvedStall", bus.stall, 1'b0);
        checkOutput("rawResolvedData", bus.readDataA, 16'hABCD);
        tick();
        applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("r3Cleared", bus.stall, 1'b0);
        tick();

        // Simultaneous issue and commit on r2.
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h0000);
        tick();
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 1, 2, 16'h2222);
        @(negedge clock);
        checkOutput("incDecStall", bus.stall, 1'b0);
        checkOutput("incDecError", bus.scoreboardError, 1'b0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("r2StillPending", bus.stall, 1'b1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 2, 0, 1, 2, 16'h2223);
        tick();

        // Saturation on r7.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0000);
            @(negedge clock);
            checkOutput("fillR7", bus.stall, 1'b0);
            tick();
        end
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("saturatedStall", bus.stall, 1'b1);
        bus.wbWrite = 1'b1;
        bus.wbAddr  = 3'd7;
        bus.wbData  = 16'h7777;
        #1;
        checkOutput("saturatedCommitStall", bus.stall, 1'b0);
        tick();
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("stillSaturated", bus.stall, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h7000 + 16'(i));
            tick();
        end
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 0, 0, 16'h0000);
        @(negedge clock);
        checkOutput("r7Drained", bus.stall, 1'b0);
        checkOutput("r7Value", bus.readDataA, 16'h7002);
        checkOutput("noErrorYet", bus.scoreboardError, 1'b0);
        tick();

        // Underflow on r1.
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 16'h0F0F);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        repeat (3) tick();
        @(negedge clock);
        checkOutput("underflowData", bus.readDataA, 16'h0F0F);
        checkOutput("underflowSticky", bus.scoreboardError, 1'b1);
        tick();
        doReset();
        @(negedge clock);
        checkOutput("errorClearedByReset", bus.scoreboardError, 1'b0);
        tick();

        // Commit counter wrap.
        applyStimulus(0, 0, 0, 6, 0, 0, 0, 1, 6, 16'h0000);
        for (int i = 0; i < 65535; i++) begin
            bus.wbData = 16'(i);
            tick();
        end
        bus.wbWrite = 1'b0;
        @(negedge clock);
        checkOutput("countAtMax", bus.writebackCount, 16'hFFFF);
        checkOutput("r6Last", bus.readDataA, 16'hFFFE);
        tick();
        bus.wbWrite = 1'b1;
        bus.wbData  = 16'hBEEF;
        tick();
        bus.wbWrite = 1'b0;
        @(negedge clock);
        checkOutput("countWrapped", bus.writebackCount, 16'h0000);
        tick();

        checkEnable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
